// File: rtl/vid_pkg.sv
// Shared types and helpers for the video frame scheduler.
package vid_pkg;

    typedef enum logic [1:0] {IDLE, REQ, STREAM, DONE} sched_state_t;

    localparam int unsigned DIM_W   = 16;
    localparam int unsigned MAX_SRC = 8;
    localparam int unsigned PTR_W   = 3;

    typedef logic [DIM_W-1:0] dim_t;

    // First set bit of mask at or after ptr, wrapping over n entries.
    function automatic logic [PTR_W-1:0] rr_pick(
        input logic [MAX_SRC-1:0] mask,
        input logic [PTR_W-1:0]   ptr,
        input int unsigned        n
    );
        logic [PTR_W-1:0] pick;
        logic [PTR_W-1:0] idx;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_SRC; i++) begin
            idx = PTR_W'((32'(ptr) + i) % n);
            if (!found && (i < n) && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/vid_frame_cnt.sv
// Pixel/line position counter; flags end-of-line, end-of-frame and start-of-frame.
module vid_frame_cnt
    import vid_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic beat_i,
    input  dim_t h_lim_i,
    input  dim_t v_lim_i,
    output logic eol_c,
    output logic eof_c,
    output logic sof_c
);

    dim_t h_cnt_q, h_cnt_d;
    dim_t v_cnt_q, v_cnt_d;

    assign eol_c = (h_cnt_q == (h_lim_i - dim_t'(1)));
    assign eof_c = eol_c && (v_cnt_q == (v_lim_i - dim_t'(1)));
    assign sof_c = (h_cnt_q == '0) && (v_cnt_q == '0);

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (clr_i) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (beat_i) begin
            if (eol_c) begin
                h_cnt_d = '0;
                v_cnt_d = v_cnt_q + dim_t'(1);
            end else begin
                h_cnt_d = h_cnt_q + dim_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

endmodule

// File: rtl/vid_frame_sched.sv
// Round-robin frame scheduler: grants whole frames from N_SRC AXI4-Stream
// video sources onto one output stream and checks tlast/tuser framing.
module vid_frame_sched
    import vid_pkg::*;
#(
    parameter int unsigned N_SRC  = 2,
    parameter int unsigned DATA_W = 24
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         enable,
    input  logic [N_SRC-1:0]             src_en,
    input  logic [DIM_W-1:0]             H_RES,
    input  logic [DIM_W-1:0]             V_RES,
    output logic [N_SRC-1:0]             frame_req,
    input  logic [N_SRC-1:0]             s_tvalid,
    output logic [N_SRC-1:0]             s_tready,
    input  logic [N_SRC*DATA_W-1:0]      s_tdata,
    input  logic [N_SRC-1:0]             s_tlast,
    input  logic [N_SRC-1:0]             s_tuser,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [DATA_W-1:0]            m_tdata,
    output logic                         m_tlast,
    output logic                         m_tuser,
    output logic [$clog2(N_SRC)-1:0]     grant,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         err_sync,
    input  logic                         err_clr
);

    localparam int unsigned SEL_W = $clog2(N_SRC);

    sched_state_t     state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    dim_t             h_lim_q, h_lim_d;
    dim_t             v_lim_q, v_lim_d;
    logic [N_SRC-1:0] frame_req_q, frame_req_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             err_q, err_d;

    logic cnt_clr_c;
    logic beat_c;
    logic viol_c;
    logic eol_c, eof_c, sof_c;

    // Zero-latency pass-through of the granted source.
    always_comb begin
        m_tvalid = 1'b0;
        s_tready = '0;
        m_tdata  = s_tdata[32'(sel_q) * DATA_W +: DATA_W];
        m_tlast  = s_tlast[sel_q];
        m_tuser  = s_tuser[sel_q];
        if (state_q == STREAM) begin
            m_tvalid        = s_tvalid[sel_q];
            s_tready[sel_q] = m_tready;
        end
    end

    assign beat_c = m_tvalid && m_tready;
    assign viol_c = beat_c && ((m_tlast != eol_c) || (m_tuser != sof_c));

    vid_frame_cnt u_cnt (
        .clk     (aclk),
        .rst_n   (aresetn),
        .clr_i   (cnt_clr_c),
        .beat_i  (beat_c),
        .h_lim_i (h_lim_q),
        .v_lim_i (v_lim_q),
        .eol_c   (eol_c),
        .eof_c   (eof_c),
        .sof_c   (sof_c)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        h_lim_d      = h_lim_q;
        v_lim_d      = v_lim_q;
        cnt_clr_c    = 1'b0;
        frame_req_d  = '0;
        busy_d       = 1'b0;
        frame_done_d = 1'b0;
        err_d        = err_q;

        unique case (state_q)
            IDLE: begin
                if (enable && (|src_en) && (H_RES != '0) && (V_RES != '0)) begin
                    sel_d     = SEL_W'(rr_pick(MAX_SRC'(src_en), PTR_W'(rr_ptr_q), N_SRC));
                    h_lim_d   = H_RES;
                    v_lim_d   = V_RES;
                    cnt_clr_c = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                grant_d = sel_q;
                state_d = STREAM;
            end
            STREAM: begin
                // Frame end is defined by the counters alone, never by source tlast.
                if (beat_c && eof_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rr_ptr_d = (sel_q == SEL_W'(N_SRC - 1)) ? '0 : sel_q + SEL_W'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == REQ) begin
            frame_req_d[sel_d] = 1'b1;
        end
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == DONE);
        // Clear takes priority over an error detected in the same cycle.
        if (err_clr) begin
            err_d = 1'b0;
        end else if (viol_c) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            h_lim_q      <= '0;
            v_lim_q      <= '0;
            frame_req_q  <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            h_lim_q      <= h_lim_d;
            v_lim_q      <= v_lim_d;
            frame_req_q  <= frame_req_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign frame_req  = frame_req_q;
    assign grant      = grant_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign err_sync   = err_q;

endmodule

// File: tb/tb_vid_frame_sched.sv
// Scoreboard bench for vid_frame_sched: randomized sources and sink, expected
// frames predicted from round-robin rules and pushed ahead of the DUT.
module tb_vid_frame_sched;

    localparam int N  = 2;
    localparam int DW = 24;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic            enable;
    logic [N-1:0]    src_en;
    logic [15:0]     H_RES, V_RES;
    logic [N-1:0]    frame_req;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tuser;
    logic            m_tvalid;
    logic            m_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tlast;
    logic            m_tuser;
    logic [0:0]      grant;
    logic            busy;
    logic            frame_done;
    logic            err_sync;
    logic            err_clr;

    vid_frame_sched #(.N_SRC(N), .DATA_W(DW)) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .src_en(src_en),
        .H_RES(H_RES), .V_RES(V_RES), .frame_req(frame_req),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tlast(s_tlast), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tlast(m_tlast), .m_tuser(m_tuser),
        .grant(grant), .busy(busy), .frame_done(frame_done),
        .err_sync(err_sync), .err_clr(err_clr)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
        int            src;
        bit            fin;
    } beat_t;

    beat_t exp_q[$];
    int    exp_req[$];

    int n_chk = 0;
    int n_pass = 0;
    int beats_seen = 0;
    int req_cnt = 0;
    int done_cnt = 0;

    int m_ptr = 0;
    int m_fcnt[N];

    int ready_mode = 0;
    int valid_mode = 0;
    bit inj_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Pixel content and framing a well-behaved source produces.
    function automatic logic [DW-1:0] pix_data(input int s, input int f, input int p);
        return {4'(s), 8'(f), 12'(p)};
    endfunction

    function automatic logic src_last(input int p, input int h, input bit inj);
        return ((p % h) == (h - 1)) || (inj && (p == 2));
    endfunction

    function automatic int pick_src(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Source frame generators and sink ready driver.
    initial begin
        int  pix[N];
        int  total[N];
        int  frm[N];
        int  fcnt[N];
        bit  active[N];
        logic acc[N];
        logic rq[N];
        for (int i = 0; i < N; i++) begin
            pix[i] = 0; total[i] = 0; frm[i] = 0; fcnt[i] = 0; active[i] = 1'b0;
        end
        s_tvalid = '0; s_tdata = '0; s_tlast = '0; s_tuser = '0; m_tready = 1'b1;
        forever begin
            @(negedge aclk);
            for (int i = 0; i < N; i++) begin
                acc[i] = s_tvalid[i] && s_tready[i];
                rq[i]  = frame_req[i];
            end
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                for (int i = 0; i < N; i++) active[i] = 1'b0;
                s_tvalid = '0;
                continue;
            end
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    pix[i]++;
                    if (pix[i] == total[i]) active[i] = 1'b0;
                end
                if (rq[i]) begin
                    active[i] = 1'b1;
                    pix[i]    = 0;
                    total[i]  = int'(H_RES) * int'(V_RES);
                    frm[i]    = fcnt[i];
                    fcnt[i]++;
                end
                if (!active[i]) s_tvalid[i] = 1'b0;
                else if (!(s_tvalid[i] && !acc[i]))
                    s_tvalid[i] = (valid_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
                s_tdata[i*DW +: DW] = pix_data(i, frm[i], pix[i]);
                s_tlast[i] = src_last(pix[i], int'(H_RES), inj_en);
                s_tuser[i] = (pix[i] == 0);
            end
            case (ready_mode)
                0: m_tready = 1'b1;
                1: m_tready = ~m_tready;
                default: m_tready = $urandom_range(0, 1) == 1;
            endcase
        end
    end

    // Monitor: pops expected requests/beats whenever the DUT presents them.
    initial begin
        bit    prev_fin = 1'b0;
        beat_t e;
        int    es;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                prev_fin = 1'b0;
                continue;
            end
            if (frame_done || prev_fin) chk("frame_done_timing", 64'(frame_done), 64'(prev_fin));
            if (frame_done) done_cnt++;
            prev_fin = 1'b0;
            if (frame_req != '0) begin
                req_cnt++;
                if (exp_req.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_req: got %0b expected none", frame_req);
                end else begin
                    es = exp_req.pop_front();
                    chk("frame_req", 64'(frame_req), 64'(1 << es));
                end
            end
            if (m_tvalid && m_tready) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_beat: got data %0h expected none", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {m_tdata, m_tlast, m_tuser, s_tready},
                        {e.data, e.last, e.user, 2'(1 << e.src)});
                    prev_fin = e.fin;
                end
            end
        end
    end

    // Predict one frame, let the DUT run it, and check completion.
    task automatic run_frame(input int h, input int v, input logic [N-1:0] mask,
                             input int rmode, input int vmode, input int drop_after,
                             input bit inj);
        int s, r0, d0, b0, k;
        s = pick_src(mask, m_ptr);
        H_RES = 16'(h); V_RES = 16'(v); src_en = mask;
        ready_mode = rmode; valid_mode = vmode; inj_en = inj;
        exp_req.push_back(s);
        for (int p = 0; p < h * v; p++) begin
            beat_t b;
            b.data = pix_data(s, m_fcnt[s], p);
            b.last = src_last(p, h, inj);
            b.user = (p == 0);
            b.src  = s;
            b.fin  = (p == h * v - 1);
            exp_q.push_back(b);
        end
        m_fcnt[s]++;
        r0 = req_cnt; d0 = done_cnt;
        enable = 1'b1;
        for (k = 0; k < 50 && req_cnt == r0; k++) begin @(posedge aclk); #1; end
        chk("req_seen", 64'(req_cnt != r0), 64'd1);
        chk("busy", 64'(busy), 64'd1);
        b0 = beats_seen;
        for (k = 0; k < 2000 && beats_seen < b0 + drop_after; k++) begin @(posedge aclk); #1; end
        enable = 1'b0;
        for (k = 0; k < 4000 && done_cnt == d0; k++) begin @(posedge aclk); #1; end
        chk("frame_done_seen", 64'(done_cnt != d0), 64'd1);
        chk("grant", 64'(grant), 64'(s));
        m_ptr = (s + 1) % N;
        inj_en = 1'b0;
    endtask

    initial begin
        int r0, b0, k, s;
        for (int i = 0; i < N; i++) m_fcnt[i] = 0;
        aresetn = 1'b0; enable = 1'b0; src_en = '0; err_clr = 1'b0;
        H_RES = 16'd4; V_RES = 16'd3;
        #12;
        chk("rst_frame_req", 64'(frame_req), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_err_sync", 64'(err_sync), 64'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;

        // Basic alternation, full-rate sink.
        run_frame(4, 3, 2'b11, 0, 0, 0, 1'b0);
        run_frame(4, 3, 2'b11, 0, 0, 0, 1'b0);
        chk("err_clean", 64'(err_sync), 64'd0);

        // Toggling ready and random valid.
        run_frame(4, 3, 2'b11, 1, 1, 0, 1'b0);
        run_frame(4, 3, 2'b11, 1, 1, 0, 1'b0);

        // Only source 1 participates.
        for (int f = 0; f < 3; f++) run_frame(4, 3, 2'b10, 0, 0, 0, 1'b0);

        // Random geometry and masks, including single-pixel lines.
        for (int f = 0; f < 8; f++)
            run_frame($urandom_range(1, 5), $urandom_range(1, 4),
                      2'($urandom_range(1, 3)), 2, 1, 0, 1'b0);
        chk("err_after_random", 64'(err_sync), 64'd0);

        // Early tlast still streams a full frame but raises err_sync.
        run_frame(4, 3, 2'b11, 0, 0, 0, 1'b1);
        chk("err_set", 64'(err_sync), 64'd1);
        err_clr = 1'b1;
        @(posedge aclk); #1;
        err_clr = 1'b0;
        chk("err_cleared", 64'(err_sync), 64'd0);

        // Enable dropped mid-frame: frame completes, no new request.
        run_frame(4, 3, 2'b11, 0, 0, 5, 1'b0);
        r0 = req_cnt;
        repeat (20) @(posedge aclk);
        #1;
        chk("no_req_after_drop", 64'(req_cnt), 64'(r0));
        chk("idle_after_drop", 64'(busy), 64'd0);

        // Reset in the middle of a source-1 frame.
        if (m_ptr == 0) run_frame(2, 2, 2'b11, 0, 0, 0, 1'b0);
        H_RES = 16'd4; V_RES = 16'd3; src_en = 2'b11; ready_mode = 0; valid_mode = 0;
        s = pick_src(src_en, m_ptr);
        exp_req.push_back(s);
        for (int p = 0; p < 12; p++) begin
            beat_t b;
            b.data = pix_data(s, m_fcnt[s], p);
            b.last = src_last(p, 4, 1'b0);
            b.user = (p == 0);
            b.src  = s;
            b.fin  = (p == 11);
            exp_q.push_back(b);
        end
        m_fcnt[s]++;
        r0 = req_cnt;
        enable = 1'b1;
        for (k = 0; k < 50 && req_cnt == r0; k++) begin @(posedge aclk); #1; end
        enable = 1'b0;
        b0 = beats_seen;
        for (k = 0; k < 200 && beats_seen < b0 + 6; k++) begin @(posedge aclk); #1; end
        chk("beats_before_reset", 64'(beats_seen - b0), 64'd6);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("mid_rst_s_tready", 64'(s_tready), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_grant", 64'(grant), 64'd0);
        chk("mid_rst_frame_req", 64'(frame_req), 64'd0);
        exp_q.delete();
        exp_req.delete();
        m_ptr = 0;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        run_frame(4, 3, 2'b11, 0, 0, 0, 1'b0);

        repeat (5) @(posedge aclk);
        #1;
        chk("exp_beats_drained", 64'(exp_q.size()), 64'd0);
        chk("exp_reqs_drained", 64'(exp_req.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
